// File: rtl/synth_spi_ctrl.sv
// SPI-programmed synthesizer parameter bank plus debounced trigger (gate / note_on).
// Config writes land SYNC_STAGES cycles after nss rises; gate follows trig after SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles.
module synth_spi_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_nss,
  input  logic        trig,
  output logic [11:0] pitch,
  output logic [11:0] attack,
  output logic [11:0] decay,
  output logic [7:0]  sustain,
  output logic [11:0] release_val,
  output logic [1:0]  wave,
  output logic        mute,
  output logic        cfg_upd,
  output logic        frame_err,
  output logic        gate,
  output logic        note_on
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, nss_q, trig_q;
  logic                   spi_clk_s, spi_mosi_s, spi_nss_s, trig_s;
  logic                   spi_clk_d, spi_nss_d;
  logic                   clk_rise, nss_fall, nss_rise;
  state_t                 state;
  logic [15:0]            shreg;
  logic [4:0]             bit_cnt;
  logic [CW-1:0]          db_cnt;

  assign spi_clk_s  = sclk_q[SYNC_STAGES-1];
  assign spi_mosi_s = mosi_q[SYNC_STAGES-1];
  assign spi_nss_s  = nss_q[SYNC_STAGES-1];
  assign trig_s     = trig_q[SYNC_STAGES-1];

  assign clk_rise = spi_clk_s & ~spi_clk_d;
  assign nss_fall = ~spi_nss_s & spi_nss_d;
  assign nss_rise = spi_nss_s & ~spi_nss_d;

  // nss chain resets low: a frame already in progress at reset release never shows a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q    <= '0;
      mosi_q    <= '0;
      nss_q     <= '0;
      trig_q    <= '0;
      spi_clk_d <= 1'b0;
      spi_nss_d <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      nss_q     <= {nss_q[SYNC_STAGES-2:0], spi_nss};
      trig_q    <= {trig_q[SYNC_STAGES-2:0], trig};
      spi_clk_d <= spi_clk_s;
      spi_nss_d <= spi_nss_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      pitch       <= 12'h100;
      attack      <= 12'h010;
      decay       <= 12'h010;
      sustain     <= 8'hC0;
      release_val <= 12'h008;
      wave        <= 2'd0;
      mute        <= 1'b0;
      cfg_upd     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      cfg_upd   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (nss_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (nss_rise) begin
            state <= IDLE;
            if (bit_cnt != 5'd16) begin
              frame_err <= 1'b1;
            end else if (shreg[15]) begin
              cfg_upd <= (shreg[14:12] <= 3'd5);
              case (shreg[14:12])
                3'd0:    pitch       <= shreg[11:0];
                3'd1:    attack      <= shreg[11:0];
                3'd2:    decay       <= shreg[11:0];
                3'd3:    sustain     <= shreg[7:0];
                3'd4:    release_val <= shreg[11:0];
                3'd5:    {mute, wave} <= shreg[2:0];
                default: ;
              endcase
            end
          end else if (clk_rise) begin
            shreg <= {shreg[14:0], spi_mosi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt  <= '0;
      gate    <= 1'b0;
      note_on <= 1'b0;
    end else begin
      note_on <= 1'b0;
      if (trig_s == gate) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt  <= '0;
        gate    <= trig_s;
        note_on <= trig_s;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synth_spi_ctrl.sv
// Directed bench for synth_spi_ctrl: SPI at clk/8, DEBOUNCE_CYCLES=16.
module tb_synth_spi_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_nss = 1'b1;
  logic        trig = 1'b0;
  logic [11:0] pitch, attack, decay, release_val;
  logic [7:0]  sustain;
  logic [1:0]  wave;
  logic        mute, cfg_upd, frame_err, gate, note_on;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd = 0;
  int n_ferr = 0;
  int n_note = 0;
  int b_upd, b_ferr, b_note;

  synth_spi_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_nss(spi_nss), .trig(trig),
    .pitch(pitch), .attack(attack), .decay(decay), .sustain(sustain),
    .release_val(release_val), .wave(wave), .mute(mute),
    .cfg_upd(cfg_upd), .frame_err(frame_err), .gate(gate), .note_on(note_on)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_upd)   n_upd++;
    if (frame_err) n_ferr++;
    if (note_on)   n_note++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [16:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = d[i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [16:0] d, input int n);
    spi_nss = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(d, n);
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
  endtask

  task automatic mark();
    b_upd  = n_upd;
    b_ferr = n_ferr;
    b_note = n_note;
  endtask

  task automatic check_regs(input string tag, input logic [11:0] p, input logic [11:0] a,
                            input logic [7:0] s, input logic [11:0] r, input logic [2:0] wm);
    check({tag, "_pitch"}, 32'(pitch), 32'(p));
    check({tag, "_attack"}, 32'(attack), 32'(a));
    check({tag, "_decay"}, 32'(decay), 32'h010);
    check({tag, "_sustain"}, 32'(sustain), 32'(s));
    check({tag, "_release"}, 32'(release_val), 32'(r));
    check({tag, "_mute_wave"}, 32'({mute, wave}), 32'(wm));
  endtask

  initial begin
    // 1. Reset values
    repeat (3) @(negedge clk);
    check_regs("rst", 12'h100, 12'h010, 8'hC0, 12'h008, 3'b000);
    check("rst_pulses", 32'({cfg_upd, frame_err, gate, note_on}), 32'h0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle_pulses", 32'(n_upd + n_ferr + n_note), 32'd0);

    // 2. Valid writes with exact commit latency
    mark();
    send(17'h08ABC, 16);
    @(negedge clk);
    @(negedge clk);
    check("lat_k1_upd", 32'(cfg_upd), 32'd0);
    check("lat_k1_pitch", 32'(pitch), 32'h100);
    @(negedge clk);
    check("lat_k2_upd", 32'(cfg_upd), 32'd1);
    check("lat_k2_pitch", 32'(pitch), 32'hABC);
    @(negedge clk);
    check("lat_k3_upd", 32'(cfg_upd), 32'd0);
    repeat (4) @(negedge clk);
    check("w1_upd_cnt", 32'(n_upd - b_upd), 32'd1);
    send(17'h0D0FF, 16);
    repeat (8) @(negedge clk);
    send(17'h0BFFF, 16);
    repeat (8) @(negedge clk);
    check_regs("w3", 12'hABC, 12'h010, 8'hFF, 12'h008, 3'b111);
    check("w3_upd_cnt", 32'(n_upd - b_upd), 32'd3);
    check("w3_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);

    // 3. Discarded frames
    mark();
    send(17'h00123, 16);
    repeat (8) @(negedge clk);
    send(17'h0E555, 16);
    repeat (8) @(negedge clk);
    check_regs("disc", 12'hABC, 12'h010, 8'hFF, 12'h008, 3'b111);
    check("disc_upd_cnt", 32'(n_upd - b_upd), 32'd0);
    check("disc_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);

    // 4. Malformed frames then recovery
    mark();
    send(17'h04123, 15);
    repeat (8) @(negedge clk);
    check("short_ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
    send(17'h18123, 17);
    repeat (8) @(negedge clk);
    check("long_ferr_cnt", 32'(n_ferr - b_ferr), 32'd2);
    check("bad_upd_cnt", 32'(n_upd - b_upd), 32'd0);
    check_regs("bad", 12'hABC, 12'h010, 8'hFF, 12'h008, 3'b111);
    send(17'h09042, 16);
    repeat (8) @(negedge clk);
    check("rec_attack", 32'(attack), 32'h042);
    check("rec_upd_cnt", 32'(n_upd - b_upd), 32'd1);
    check("rec_ferr_cnt", 32'(n_ferr - b_ferr), 32'd2);

    // 5. Trigger debounce
    mark();
    trig = 1'b1;
    repeat (10) @(negedge clk);
    trig = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_gate", 32'(gate), 32'd0);
    check("glitch_note", 32'(n_note - b_note), 32'd0);
    trig = 1'b1;
    repeat (17) @(negedge clk);
    check("rise_k16_gate", 32'(gate), 32'd0);
    @(negedge clk);
    check("rise_k17_gate", 32'(gate), 32'd1);
    check("rise_k17_note", 32'(note_on), 32'd1);
    @(negedge clk);
    check("rise_k18_note", 32'(note_on), 32'd0);
    repeat (21) @(negedge clk);
    trig = 1'b0;
    repeat (17) @(negedge clk);
    check("fall_k16_gate", 32'(gate), 32'd1);
    @(negedge clk);
    check("fall_k17_gate", 32'(gate), 32'd0);
    repeat (10) @(negedge clk);
    check("trig_note_cnt", 32'(n_note - b_note), 32'd1);

    // 6. Reset mid-frame with nss held low across release
    spi_nss = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(17'h0008A, 8);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_pitch", 32'(pitch), 32'h100);
    rstn = 1'b1;
    mark();
    shift_bits(17'h000BC, 8);
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_upd_cnt", 32'(n_upd - b_upd), 32'd0);
    check("mid_ferr_cnt", 32'(n_ferr - b_ferr), 32'd0);
    check_regs("mid", 12'h100, 12'h010, 8'hC0, 12'h008, 3'b000);
    send(17'h0C3AA, 16);
    repeat (8) @(negedge clk);
    check("post_release", 32'(release_val), 32'h3AA);
    check("post_pitch", 32'(pitch), 32'h100);
    check("post_upd_cnt", 32'(n_upd - b_upd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
